// File: rtl/vip_window_gen.sv
// vip_window_gen: buffers WIN-1 lines and emits a WIN x WIN window per pixel, with border fill, coordinates and overflow flag.
// Latency: 2 cycles in_de -> out_de; there is no backpressure and a pixel can be accepted every cycle.
module vip_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int WIN    = 3,
    parameter int BORDER = 0,
    parameter int CW     = $clog2(IMG_W + 1),
    parameter int RW     = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vsync,
    input  logic                      in_href,
    input  logic                      in_de,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_vsync,
    output logic                      out_href,
    output logic                      out_de,
    output logic [WIN*WIN*DATA_W-1:0] out_win,
    output logic [CW-1:0]             out_col,
    output logic [RW-1:0]             out_row,
    output logic                      out_edge,
    output logic                      out_ovf
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int IW = $clog2(WIN);

    typedef struct packed {
        logic          vsync;
        logic          href;
        logic          de;
        logic          pix;
        logic          first;
        logic          ovf;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } meta_t;

    logic          vs_q;
    logic          href_q;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          vs_rise;
    logic          href_fall;
    logic          pix;
    logic          in_ovf;
    logic          wr0;
    logic [AW-1:0] addr;

    assign vs_rise   = in_vsync & ~vs_q;
    assign href_fall = href_q & ~in_href;
    assign pix       = in_href & in_de;
    assign in_ovf    = (col >= CW'(IMG_W));
    assign wr0       = pix & ~in_ovf;
    assign addr      = in_ovf ? '0 : col[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            href_q <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            vs_q   <= in_vsync;
            href_q <= in_href;
            if (vs_rise || href_fall)
                col <= '0;
            else if (pix && (col != {CW{1'b1}}))
                col <= col + 1'b1;
            // a vsync edge wins over the line-end increment
            if (vs_rise)
                row <= '0;
            else if (href_fall && (col != '0) && (row != {RW{1'b1}}))
                row <= row + 1'b1;
        end
    end

    meta_t             s1;
    logic [DATA_W-1:0] d1;
    logic              wr_en_q;
    logic [AW-1:0]     wr_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            d1        <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            s1.vsync  <= in_vsync;
            s1.href   <= in_href;
            s1.de     <= in_de;
            s1.pix    <= pix;
            s1.first  <= (col == '0);
            s1.ovf    <= in_ovf;
            s1.col    <= col;
            s1.row    <= row;
            d1        <= in_data;
            wr_en_q   <= wr0;
            wr_addr_q <= addr;
        end
    end

    // RAM k holds line row-1-k; deeper RAMs are fed one cycle later from the previous read.
    logic [DATA_W-1:0] tap [WIN-1];

    for (genvar k = 0; k < WIN - 1; k++) begin : g_line
        logic [DATA_W-1:0] mem [IMG_W];
        logic [DATA_W-1:0] rd_q;
        logic              we;
        logic [AW-1:0]     wa;
        logic [DATA_W-1:0] wd;

        if (k == 0) begin : g_head
            assign we = wr0;
            assign wa = addr;
            assign wd = in_data;
        end else begin : g_tail
            assign we = wr_en_q;
            assign wa = wr_addr_q;
            assign wd = tap[k-1];
        end

        always_ff @(posedge clk) begin
            rd_q <= mem[addr];
            if (we)
                mem[wa] <= wd;
        end

        assign tap[k] = rd_q;
    end

    logic [DATA_W-1:0] raw [WIN];
    logic [DATA_W-1:0] vec [WIN];
    logic [IW-1:0]     rep_idx;
    logic              edge_nxt;

    always_comb begin
        rep_idx = IW'(WIN - 1);
        for (int i = 0; i < WIN - 1; i++)
            if (s1.row == RW'(i))
                rep_idx = IW'(WIN - 1 - i);
        for (int r = 0; r < WIN - 1; r++)
            raw[r] = s1.ovf ? '0 : tap[WIN-2-r];
        raw[WIN-1] = d1;
        // rows above the frame top are zeroed or replaced by the oldest real row
        for (int r = 0; r < WIN; r++) begin
            vec[r] = raw[r];
            if (s1.row < RW'(WIN - 1 - r))
                vec[r] = (BORDER == 1) ? raw[rep_idx] : '0;
        end
        edge_nxt = (s1.row < RW'(WIN - 1)) | (s1.col < CW'(WIN - 1));
    end

    logic [DATA_W-1:0] win_q [WIN][WIN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    win_q[r][c] <= '0;
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_de    <= 1'b0;
            out_col   <= '0;
            out_row   <= '0;
            out_edge  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_vsync <= s1.vsync;
            out_href  <= s1.href;
            out_de    <= s1.de;
            if (!s1.href) begin
                for (int r = 0; r < WIN; r++)
                    for (int c = 0; c < WIN; c++)
                        win_q[r][c] <= '0;
            end else if (s1.pix) begin
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN - 1; c++)
                        win_q[r][c] <= s1.first ? ((BORDER == 1) ? vec[r] : '0) : win_q[r][c+1];
                    win_q[r][WIN-1] <= vec[r];
                end
                out_col  <= s1.col;
                out_row  <= s1.row;
                out_edge <= edge_nxt;
            end
            if (s1.vsync && !out_vsync)
                out_ovf <= 1'b0;
            else if (s1.pix && s1.ovf)
                out_ovf <= 1'b1;
        end
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            assign out_win[(r*WIN+c)*DATA_W +: DATA_W] = win_q[r][c];
        end
    end

endmodule

// File: tb/tb_vip_window_gen.sv
// Directed bench for vip_window_gen: four configurations share one ramp-frame stimulus; every pixel is
// compared against an image-domain reference plus hand-computed windows at the called-out positions.
module tb_vip_window_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vsync, in_href, in_de;
    logic [9:0] in_data;

    always #5 clk = ~clk;

    logic vs0, hr0, de0, eg0, ov0; logic [71:0]  w0; logic [9:0] col0; logic [11:0] row0;
    logic vs1, hr1, de1, eg1, ov1; logic [71:0]  w1; logic [9:0] col1; logic [11:0] row1;
    logic vs2, hr2, de2, eg2, ov2; logic [249:0] w2; logic [9:0] col2; logic [11:0] row2;
    logic vs3, hr3, de3, eg3, ov3; logic [71:0]  w3; logic [3:0] col3; logic [11:0] row3;

    vip_window_gen #(.DATA_W(8), .IMG_W(640), .WIN(3), .BORDER(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_de(in_de),
        .in_data(in_data[7:0]), .out_vsync(vs0), .out_href(hr0), .out_de(de0), .out_win(w0),
        .out_col(col0), .out_row(row0), .out_edge(eg0), .out_ovf(ov0));
    vip_window_gen #(.DATA_W(8), .IMG_W(640), .WIN(3), .BORDER(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_de(in_de),
        .in_data(in_data[7:0]), .out_vsync(vs1), .out_href(hr1), .out_de(de1), .out_win(w1),
        .out_col(col1), .out_row(row1), .out_edge(eg1), .out_ovf(ov1));
    vip_window_gen #(.DATA_W(10), .IMG_W(640), .WIN(5), .BORDER(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_de(in_de),
        .in_data(in_data), .out_vsync(vs2), .out_href(hr2), .out_de(de2), .out_win(w2),
        .out_col(col2), .out_row(row2), .out_edge(eg2), .out_ovf(ov2));
    vip_window_gen #(.DATA_W(8), .IMG_W(8), .WIN(3), .BORDER(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_de(in_de),
        .in_data(in_data[7:0]), .out_vsync(vs3), .out_href(hr3), .out_de(de3), .out_win(w3),
        .out_col(col3), .out_row(row3), .out_edge(eg3), .out_ovf(ov3));

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int scn, fw, t_in;
    int k_a [4];
    bit ovf_e [4];
    bit pvs [4];
    bit phr [4];
    logic [255:0] pw [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int win_of(input int id);
        return (id == 2) ? 5 : 3;
    endfunction

    function automatic int imgw_of(input int id);
        return (id == 3) ? 8 : 640;
    endfunction

    // Window expected for the pixel at (rr, cc) of a ramp frame, pixel = 16*row + col.
    function automatic logic [255:0] model(input int id, input int rr, input int cc);
        int win, dw, sr, sc;
        bit bord, ok;
        logic [255:0] res, v;
        win  = win_of(id);
        dw   = (id == 2) ? 10 : 8;
        bord = (id == 1);
        res  = '0;
        for (int r = 0; r < win; r++) begin
            for (int c = 0; c < win; c++) begin
                sr = rr - (win - 1) + r;
                sc = cc - (win - 1) + c;
                ok = 1'b1;
                if (sr < 0) begin if (bord) sr = 0; else ok = 1'b0; end
                if (sc < 0) begin if (bord) sc = 0; else ok = 1'b0; end
                if (r < win - 1 && sc >= imgw_of(id)) ok = 1'b0;
                v   = ok ? 256'(16 * sr + sc) : '0;
                res = res | (v << ((r * win + c) * dw));
            end
        end
        return res;
    endfunction

    task automatic mon(input int id, input logic vs, hr, de, eg, ov, input logic [255:0] w,
                       input logic [15:0] col, row);
        int er, ec, ws;
        string tg;
        ws = win_of(id);
        tg = $sformatf("u%0d s%0d k%0d", id, scn, k_a[id]);
        if (!rst_n) begin
            chk({tg, " reset win"}, w, '0);
            chk({tg, " reset ctl"}, 256'({vs, hr, de, eg, ov, col, row}), '0);
            k_a[id] = 0; ovf_e[id] = 1'b0; pvs[id] = 1'b0; phr[id] = 1'b0; pw[id] = '0;
        end else begin
            if (vs && !pvs[id]) begin
                k_a[id] = 0;
                ovf_e[id] = 1'b0;
            end
            if (de) begin
                er = k_a[id] / fw;
                ec = k_a[id] % fw;
                tg = $sformatf("u%0d s%0d r%0d c%0d", id, scn, er, ec);
                if (ec >= imgw_of(id)) ovf_e[id] = 1'b1;
                chk({tg, " win"}, w, model(id, er, ec));
                chk({tg, " col"}, 256'(col), 256'(ec));
                chk({tg, " row"}, 256'(row), 256'(er));
                chk({tg, " edge"}, 256'(eg), 256'((er < ws - 1) || (ec < ws - 1)));
                chk({tg, " ovf"}, 256'(ov), 256'(ovf_e[id]));
                if (id == 0 && scn == 1 && k_a[id] == 0)
                    chk({tg, " latency"}, 256'(cyc - t_in), 256'(2));
                if (id == 0 && scn == 1 && er == 0 && ec == 0)
                    chk({tg, " hand"}, w, 256'(72'h0));
                if (id == 0 && scn == 1 && er == 0 && ec == 1)
                    chk({tg, " hand"}, w, 256'(72'h010000000000000000));
                if (id == 0 && scn == 1 && er == 2 && ec == 2)
                    chk({tg, " hand"}, w, 256'(72'h222120121110020100));
                if (id == 1 && scn == 1 && er == 0 && ec == 1)
                    chk({tg, " hand"}, w, 256'(72'h010000010000010000));
                if (id == 1 && scn == 1 && er == 1 && ec == 2)
                    chk({tg, " hand"}, w, 256'(72'h121110020100020100));
                if (id == 2 && scn == 2 && er == 4 && ec == 4)
                    chk({tg, " centre"}, 256'(w[129:120]), 256'(10'h022));
                if (id == 3 && scn == 3 && er == 1 && ec == 9)
                    chk({tg, " hand"}, w, 256'(72'h191817000007000000));
                k_a[id]++;
            end else if (hr && phr[id]) begin
                chk({tg, " hold"}, w, pw[id]);
            end else if (!hr) begin
                chk({tg, " idle"}, w, '0);
            end
            pvs[id] = vs;
            phr[id] = hr;
            pw[id]  = w;
        end
    endtask

    always @(negedge clk) begin
        mon(0, vs0, hr0, de0, eg0, ov0, 256'(w0), 16'(col0), 16'(row0));
        mon(1, vs1, hr1, de1, eg1, ov1, 256'(w1), 16'(col1), 16'(row1));
        mon(2, vs2, hr2, de2, eg2, ov2, 256'(w2), 16'(col2), 16'(row2));
        mon(3, vs3, hr3, de3, eg3, ov3, 256'(w3), 16'(col3), 16'(row3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int w, input int h, input bit gap);
        bit first;
        fw = w;
        in_vsync = 1'b1; tick();
        in_vsync = 1'b0; tick(); tick();
        first = 1'b1;
        for (int r = 0; r < h; r++) begin
            in_href = 1'b1;
            for (int c = 0; c < w; c++) begin
                if (gap) begin
                    in_de = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
                in_de   = 1'b1;
                in_data = 10'(16 * r + c);
                if (first) begin
                    t_in  = cyc;
                    first = 1'b0;
                end
                tick();
            end
            in_de = 1'b0; in_href = 1'b0; in_data = '0;
            tick(); tick();
        end
        repeat (4) tick();
        for (int i = 0; i < 4; i++)
            chk($sformatf("u%0d s%0d pixel count", i, scn), 256'(k_a[i]), 256'(w * h));
    endtask

    initial begin
        rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_de = 1'b0; in_data = '0;
        scn = 0; fw = 1; t_in = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick(); tick();

        scn = 1; frame(4, 4, 1'b0);
        scn = 2; frame(6, 6, 1'b0);
        scn = 4; frame(6, 6, 1'b1);
        scn = 3; frame(10, 3, 1'b0);
        chk("u3 ovf sticky after frame", 256'(ov3), 256'(1));
        scn = 5; frame(4, 4, 1'b0);
        chk("u3 ovf after new frame", 256'(ov3), 256'(0));

        // reset lands in the middle of a line
        scn = 6; fw = 4;
        in_vsync = 1'b1; tick();
        in_vsync = 1'b0; tick();
        in_href = 1'b1; in_de = 1'b1; in_data = 10'd0; tick();
        in_data = 10'd1; tick();
        in_data = 10'd2; rst_n = 1'b0; tick(); tick();
        in_href = 1'b0; in_de = 1'b0; in_data = '0; tick();
        rst_n = 1'b1; tick(); tick();

        scn = 1; frame(4, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
